// File: rtl/btb_update_scheduler.sv
// Buffers resolved branches and drains them to the BTB update port. It also
// raises mispredict redirects, squashes wrong-path resolutions and runs BTB invalidate walks.
module btb_update_scheduler #(
  parameter int DEPTH         = 4,
  parameter int IDX_W         = 3,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memory_stall,
  input  logic             res_valid,
  input  logic             res_is_branch,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic             res_prev_taken,
  input  logic [31:0]      res_pred_target,
  input  logic [31:0]      res_target,
  output logic             stall_req,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic             upd_prev_taken,
  output logic             upd_inv,
  output logic [IDX_W-1:0] upd_idx,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             inv_req,
  output logic             inv_done,
  output logic [1:0]       dbg_state
);
  // Handshake: a resolution is consumed on a rising edge where res_valid is high
  // and stall_req is low; while stall_req is high upstream holds it unchanged.
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_INVAL = 2'd2} state_t;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SQ_W  = $clog2(SQUASH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [SQ_W-1:0]  SQ_LOAD  = SQ_W'(SQUASH_CYCLES);

  state_t           state, state_nxt;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      tgt_mem   [DEPTH];
  logic             taken_mem [DEPTH];
  logic             prev_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SQ_W-1:0]  sq_cnt;
  logic [IDX_W-1:0] inv_idx;
  logic             empty, full, pop, accept, branch_ok, mispred;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign branch_ok = res_valid & res_is_branch & (sq_cnt == '0);
  assign accept    = (state == ST_RUN) & branch_ok & (~full | pop);
  assign mispred   = (res_taken != res_prev_taken) |
                     (res_taken & res_prev_taken & (res_pred_target != res_target));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (inv_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (empty) state_nxt = ST_INVAL;
      ST_INVAL: if (!memory_stall && inv_idx == LAST_IDX) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Entry fields are zeroed unless a write is strobed so idle outputs stay quiet.
  always_comb begin
    pop            = (state != ST_INVAL) & ~empty & ~memory_stall;
    upd_valid      = pop;
    upd_pc         = pop ? pc_mem[rd_ptr]    : 32'd0;
    upd_target     = pop ? tgt_mem[rd_ptr]   : 32'd0;
    upd_taken      = pop & taken_mem[rd_ptr];
    upd_prev_taken = pop & prev_mem[rd_ptr];
    upd_inv        = (state == ST_INVAL) & ~memory_stall;
    upd_idx        = inv_idx;
    stall_req      = ((state == ST_RUN) & branch_ok & full & ~pop) |
                     ((state != ST_RUN) & res_valid);
    dbg_state      = state;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr]    <= res_pc;
      tgt_mem[wr_ptr]   <= res_target;
      taken_mem[wr_ptr] <= res_taken;
      prev_mem[wr_ptr]  <= res_prev_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      sq_cnt         <= '0;
      inv_idx        <= '0;
      inv_done       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The squash window runs in real cycles, independent of memory_stall.
      if (accept && mispred)  sq_cnt <= SQ_LOAD;
      else if (sq_cnt != '0)  sq_cnt <= sq_cnt - 1'b1;
      redirect_valid <= accept & mispred;
      if (accept && mispred) redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
      if (state == ST_DRAIN)  inv_idx <= '0;
      else if (upd_inv)       inv_idx <= inv_idx + 1'b1;
      inv_done <= upd_inv & (inv_idx == LAST_IDX);
    end
  end
endmodule
